// File: rtl/req8_arb_pkg.sv
// Shared types and helpers for the 8-requester arbiter.
// Optional round-robin policy: REQ8_ARB_ROUND_ROBIN_EN.
package req8_arb_pkg;

    localparam int NREQ = 8;
    localparam int ID_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [NREQ-1:0] onehot8(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] v;
        v = 8'd1 << id;
        return v;
    endfunction

endpackage

// File: rtl/req8_arb_if.sv
// Request/grant bundle between requester agents and the arbiter.
// master = requester side, slave = arbiter side.
import req8_arb_pkg::*;

interface req8_arb_if;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/req8_prienc.sv
// Combinational 8-to-3 priority encoder, highest set bit wins.
// idx is 0 when no bit is set.
import req8_arb_pkg::*;

module req8_prienc (
    input  logic [NREQ-1:0] in,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = |in;
        for (int i = 0; i < NREQ; i++) begin
            if (in[i]) idx = ID_W'(i);
        end
    end
endmodule

// File: rtl/req8_arbiter.sv
// Holding arbiter for one shared resource among 8 requesters with timeout.
// Fixed priority by default; REQ8_ARB_ROUND_ROBIN_EN selects round-robin.
import req8_arb_pkg::*;

module req8_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    req8_arb_if.slave  bus
);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   mask_q, mask_d;

    logic [NREQ-1:0]   eff;
    logic [NREQ-1:0]   enc_in;
    logic [ID_W-1:0]   enc_idx;
    logic              any;
    logic [ID_W-1:0]   win;

    assign eff = bus.req & mask_q;

    req8_prienc u_enc (
        .in  (enc_in),
        .idx (enc_idx),
        .any (any)
    );

`ifdef REQ8_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] start;
    logic [ID_W-1:0] k;

    // Bit-reverse after rotating so start lands on the encoder's top bit.
    always_comb begin
        start  = last_q + 3'd1;
        enc_in = '0;
        k      = '0;
        for (int j = 0; j < NREQ; j++) begin
            k         = start + ID_W'(NREQ - 1 - j);
            enc_in[j] = eff[k];
        end
    end

    assign win = start + ID_W'(NREQ - 1) - enc_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 3'd7;
        else        last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && any) last_d = win;
    end
`else
    assign enc_in = eff;
    assign win    = enc_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    gnt_d   = onehot8(win);
                    id_d    = win;
                    cnt_d   = CNT_W'(1);
                    mask_d  = '1;
                end else if (|bus.req) begin
                    mask_d  = '1;
                end
            end
            GRANT: begin
                // Release wins over a coincident timeout.
                if (!bus.req[id_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                    mask_d  = '1;
                end else if (cnt_q == HOLD) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    mask_d  = ~onehot8(id_q);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_req8_arbiter.sv
// Scoreboard bench for req8_arbiter against a behavioural holder model.
// Directed plan sequences followed by randomized request traffic.
module tb_req8_arbiter;
    import req8_arb_pkg::*;

    localparam int MH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    req8_arb_if bus ();

    req8_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: who holds, for how long, who sits out the next arbitration.
    int         holder = -1;
    int         held   = 0;
    int         last   = 7;
    logic [7:0] excl   = '0;

    function automatic void model_reset();
        holder = -1;
        held   = 0;
        last   = 7;
        excl   = '0;
    endfunction

    function automatic int pick(input logic [7:0] e);
        int w;
        w = -1;
`ifdef REQ8_ARB_ROUND_ROBIN_EN
        for (int s = 1; s <= 8; s++)
            if (w < 0 && e[(last + s) % 8]) w = (last + s) % 8;
`else
        for (int i = 7; i >= 0; i--)
            if (w < 0 && e[i]) w = i;
`endif
        return w;
    endfunction

    function automatic exp_t model_step(input logic [7:0] r);
        exp_t e;
        int   w;
        logic t;
        t = 1'b0;
        if (holder < 0) begin
            w = pick(r & ~excl);
            if (w >= 0) begin
                holder = w;
                held   = 1;
                excl   = '0;
                last   = w;
            end else if (r != 0) begin
                excl = '0;
            end
        end else if (!r[holder]) begin
            holder = -1;
            excl   = '0;
        end else if (held == MH) begin
            excl   = 8'(1 << holder);
            holder = -1;
            t      = 1'b1;
        end else begin
            held++;
        end
        e.gnt = (holder < 0) ? 8'h00 : 8'(1 << holder);
        e.id  = (holder < 0) ? 3'd0 : 3'(holder);
        e.v   = (holder >= 0);
        e.to  = t;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.gnt = bus.gnt;
        a.id  = bus.gnt_id;
        a.v   = bus.gnt_valid;
        a.to  = bus.timeout;
        return a;
    endfunction

    function automatic void chk(input string nm, input exp_t a, input exp_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                     nm, a.gnt, a.id, a.v, a.to, e.gnt, e.id, e.v, e.to);
        end
    endfunction

    function automatic exp_t mk(input logic [7:0] g, input logic [2:0] id, input logic to);
        exp_t e;
        e.gnt = g;
        e.id  = id;
        e.v   = (g != 0);
        e.to  = to;
        return e;
    endfunction

    always @(posedge clk)
        if (rst_n) q.push_back(model_step(bus.req));

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("scoreboard", actual(), e);
        end
    end

    task automatic drive(input logic [7:0] r, input int n);
        bus.req = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset", actual(), mk(8'h00, 3'd0, 1'b0));
        #2;
        q.delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        bus.req = '0;
        #2;
        chk("reset_state", actual(), mk(8'h00, 3'd0, 1'b0));
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef REQ8_ARB_ROUND_ROBIN_EN
        drive(8'b0010_0101, 1);
        chk("fixed_first", actual(), mk(8'h20, 3'd5, 1'b0));
        drive(8'b0000_0101, 1);
        chk("release_dead", actual(), mk(8'h00, 3'd0, 1'b0));
        drive(8'b0000_0101, 1);
        chk("fixed_second", actual(), mk(8'h04, 3'd2, 1'b0));
        drive(8'h84, 3);
        chk("hold_ignores", actual(), mk(8'h04, 3'd2, 1'b0));
        drive(8'h80, 1);
        chk("hold_release", actual(), mk(8'h00, 3'd0, 1'b0));
        drive(8'h80, 1);
        chk("after_hold", actual(), mk(8'h80, 3'd7, 1'b0));
        drive(8'h00, 2);

        drive(8'h81, 4);
        chk("hold_max", actual(), mk(8'h80, 3'd7, 1'b0));
        drive(8'h81, 1);
        chk("timeout_pulse", actual(), mk(8'h00, 3'd0, 1'b1));
        drive(8'h81, 1);
        chk("timeout_next", actual(), mk(8'h01, 3'd0, 1'b0));
        drive(8'h00, 2);

        drive(8'h08, 5);
        chk("lone_timeout", actual(), mk(8'h00, 3'd0, 1'b1));
        drive(8'h08, 1);
        chk("lone_idle", actual(), mk(8'h00, 3'd0, 1'b0));
        drive(8'h08, 1);
        chk("lone_regrant", actual(), mk(8'h08, 3'd3, 1'b0));
        drive(8'h00, 2);
`endif

        drive(8'h10, 2);
        mid_reset();
        @(posedge clk);
        #1;
        chk("reset_regrant", actual(), mk(8'h10, 3'd4, 1'b0));
        drive(8'h00, 2);

`ifdef REQ8_ARB_ROUND_ROBIN_EN
        mid_reset();
        drive(8'h00, 1);
        for (int i = 0; i < 9; i++) begin
            drive(8'hFF, 1);
            chk("rr_order", actual(), mk(8'(1 << (i % 8)), 3'(i % 8), 1'b0));
            drive(8'hFF & ~8'(1 << (i % 8)), 1);
        end
        drive(8'h00, 2);
`endif

        r = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if (holder >= 0 && $urandom_range(0, 5) == 0) r[holder] = 1'b0;
            if ($urandom_range(0, 15) == 0) r = 8'(1 << $urandom_range(0, 7));
            drive(r, 1);
        end
        drive(8'h00, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
